// File: rtl/regfile_mp.sv
// Multi-read-port register file with a reservation scoreboard and a power-up zeroing sweep.
// Optional same-cycle write-to-read forwarding is enabled with macro REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   ready,
  output logic                   init_err
);

  // state   | meaning
  // ST_INIT | zeroing sweep over all registers, traffic ignored
  // ST_RUN  | normal read/write/reserve operation
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [DEPTH-1:0]    r_pend;
  logic                r_init_err;
  logic                w_run;
  logic                w_wr;
  logic                w_rsv;

  assign w_run    = (r_state == ST_RUN);
  assign w_wr     = w_run && wr_en && (wr_addr != '0);
  assign w_rsv    = w_run && rsv_en && (rsv_addr != '0);
  assign ready    = w_run;
  assign init_err = r_init_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_init_cnt == LAST) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_init_cnt <= '0;
    else if (!w_run) r_init_cnt <= r_init_cnt + 1'b1;
  end

  // Storage has no reset; the sweep zeroes it after every reset release.
  always_ff @(posedge clk) begin
    if (!w_run)    r_regs[r_init_cnt] <= '0;
    else if (w_wr) r_regs[wr_addr]    <= wr_data;
  end

  // Reserve is assigned last so it wins over a same-address write clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (w_wr)  r_pend[wr_addr]  <= 1'b0;
      if (w_rsv) r_pend[rsv_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_init_err <= 1'b0;
    else if (!w_run && (wr_en || rsv_en)) r_init_err <= 1'b1;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;
    logic              w_byp;

    assign w_ra  = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit = w_run && (w_ra != '0);
`ifdef REGFILE_BYPASS_EN
    assign w_byp = w_wr && (wr_addr == w_ra);
`else
    assign w_byp = 1'b0;
`endif
    assign rd_data[k*DATA_W +: DATA_W] = !w_hit ? '0 : (w_byp ? wr_data : r_regs[w_ra]);
    assign rd_busy[k] = w_hit && (w_byp ? (w_rsv && (rsv_addr == w_ra)) : r_pend[w_ra]);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes model expectations, a negedge monitor compares.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              ready;
  logic              init_err;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .ready(ready), .init_err(init_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          b0;
    logic          b1;
    logic          rdy;
    logic          err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural contents, pending set, cycles since reset release.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];
  int            m_cnt;
  bit            m_err;

  function automatic bit m_ready();
    return m_cnt >= DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_cnt = 0;
    m_err = 0;
  endtask

  function automatic logic [DW-1:0] exp_data(input int a, input bit we, input int wa,
                                             input logic [DW-1:0] wd);
    if (!m_ready() || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit we, input int wa,
                                    input bit re, input int ra);
    if (!m_ready() || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return re && (ra == a);
`endif
    return m_pend[a];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data0", rd_data[DW-1:0], e.d0);
      chk("rd_data1", rd_data[2*DW-1:DW], e.d1);
      chk("rd_busy0", DW'(rd_busy[0]), DW'(e.b0));
      chk("rd_busy1", DW'(rd_busy[1]), DW'(e.b1));
      chk("ready", DW'(ready), DW'(e.rdy));
      chk("init_err", DW'(init_err), DW'(e.err));
    end
  end

  // One clock of stimulus; called at posedge+1.
  task automatic cyc(input bit we, input int wa, input logic [DW-1:0] wd,
                     input bit re, input int ra, input int a0, input int a1);
    exp_t e;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rsv_en = re; rsv_addr = AW'(ra);
    rd_addr = {AW'(a1), AW'(a0)};
    e.d0 = exp_data(a0, we, wa, wd);
    e.d1 = exp_data(a1, we, wa, wd);
    e.b0 = exp_busy(a0, we, wa, re, ra);
    e.b1 = exp_busy(a1, we, wa, re, ra);
    e.rdy = m_ready();
    e.err = m_err;
    q.push_back(e);
    @(posedge clk);
    if (!m_ready()) begin
      if (we || re) m_err = 1;
      m_cnt++;
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 0;
      end
      if (re && ra != 0) m_pend[ra] = 1;
    end
    #1;
  endtask

  // Asynchronous reset between edges; outputs must collapse before any clock edge.
  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    wr_en = 0; rsv_en = 0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    rd_addr = {AW'(7), AW'(5)};
    #1;
    model_reset();
    e.d0 = '0; e.d1 = '0; e.b0 = 0; e.b1 = 0; e.rdy = 0; e.err = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_cyc(input int span);
    cyc(($urandom_range(0, 2) == 0), $urandom_range(0, span), $urandom,
        ($urandom_range(0, 3) == 0), $urandom_range(0, span),
        $urandom_range(0, span), $urandom_range(0, span));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected run to finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    wr_en = 0; rsv_en = 0; wr_addr = '0; rsv_addr = '0; wr_data = '0; rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Sweep: ready low for exactly DEPTH cycles, then all registers read zero.
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, 0, 0, i, DEPTH - 1 - i);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, 0, 0, i, DEPTH - 1 - i);

    cyc(1, 5, 32'hDEADBEEF, 0, 0, 1, 2);
    cyc(0, 0, '0, 0, 0, 5, 5);
    cyc(1, 0, 32'h00001234, 0, 0, 0, 5);
    cyc(0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, '0, 1, 7, 0, 0);
    cyc(0, 0, '0, 0, 0, 7, 7);
    cyc(1, 7, 32'h00000055, 0, 0, 7, 1);
    cyc(0, 0, '0, 0, 0, 7, 7);
    cyc(1, 9, 32'h99999999, 1, 9, 9, 0);
    cyc(0, 0, '0, 0, 0, 9, 9);
    cyc(1, 3, 32'h11111111, 0, 0, 0, 0);
    cyc(1, 3, 32'hA5A5A5A5, 0, 0, 3, 3);
    cyc(0, 0, '0, 0, 0, 3, 3);
    cyc(1, 12, 32'h0BADF00D, 1, 12, 12, 12);
    cyc(0, 0, '0, 0, 0, 12, 12);

    for (int i = 0; i < 250; i++) rand_cyc(7);
    for (int i = 0; i < 100; i++) rand_cyc(DEPTH - 1);

    // Reset mid-RUN, then a write pulse during INIT and a second reset at sweep index 10.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) cyc(1, 4, 32'hCAFEF00D, 0, 0, 4, 0);
      else        cyc(0, 0, '0, 0, 0, 4, 0);
    end
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, '0, 0, 0, 4, i % DEPTH);
    for (int i = 0; i < 60; i++) rand_cyc(7);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
